alu_ctrl_muldiv: RTL and testbench
==================================

Name: alu_ctrl_muldiv

Overview:
- Successor to the single-cycle ALU control decoder.
- Decodes opcode/funct3/funct7 into the 4-bit main-ALU operation for R, I, S, L and branch instructions.
- Adds the RV32M extension through an iterative multi-cycle multiply/divide engine that stalls the pipeline until its result is ready.
- Sits between instruction decode and the execute stage; drives the main ALU op, the writeback result mux select and the pipeline stall line.

Parameters:
- XLEN, 32, datapath width of operands and result; must be even and at least 8.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  instruction present and operands valid this cycle.
- opcode_i  in  5  instruction bits [6:2].
- f7_i  in  7  funct7, full field.
- f3_i  in  3  funct3.
- rs1_i  in  XLEN  operand A.
- rs2_i  in  XLEN  operand B.
- aluoperacion_o  out  4  main-ALU operation.
- sel_md_o  out  1  writeback takes md_result_o instead of the ALU result.
- stall_o  out  1  hold PC and the decode stage.
- md_valid_o  out  1  one-cycle pulse; md_result_o is valid.
- md_result_o  out  XLEN  multiply/divide result.
- illegal_o  out  1  undecodable combination.

Behaviour:
- Interface: one clock (clk_i); synchronous active-high reset (rst_i). All state updates on the rising edge of clk_i.
- ALU op encodings: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 1001, SRL 1010, SRA 1011.
- Decode is combinational and fully specified. The default is ADD with illegal_o=1, so no latches are inferred.
- R (01100), f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- R, f7=0100000: f3 000 SUB, 101 SRA. Any other f3 is illegal.
- I (00100): funct7 is ignored except for f3=001 and f3=101.
  - SLLI requires f7=0000000.
  - SRLI requires f7=0000000; SRAI requires f7=0100000.
  - Any other f7 on f3=001 or f3=101 is illegal.
- S (01000) and L (00000): ADD.
- Branch (11000): f3 00x SUB, 10x SLT, 11x SLTU, 01x illegal.
- M op: opcode 01100, f7=0000001.
  - f3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - aluoperacion_o=ADD and sel_md_o=1 while an M op is decoded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on valid_i & M op, latch operand magnitudes, sign flags, f3 and counter=XLEN, then go to BUSY. stall_o is asserted combinationally in this same cycle.
  - BUSY: one iteration per cycle (shift-add multiply using a 2*XLEN accumulator, or restoring divide). The counter decrements each cycle; when counter==1 the next state is DONE. stall_o=1.
  - DONE: md_valid_o=1, stall_o=0, md_result_o applies the final sign correction. Next state is IDLE. The still-present instruction is not relaunched.
- Latency: accept in cycle 0; result in cycle XLEN+1; XLEN+2 total cycles per M op.
- Divide fast path: IDLE goes straight to DONE with result ready in cycle 1.
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV gives the dividend; REM gives 0.
- Signedness:
  - MULH: signed × signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: unsigned × unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - The remainder takes the sign of the dividend.
- valid_i is ignored in BUSY and DONE. Operands are captured at acceptance, so upstream changes during the stall have no effect.
- Reset, including mid-operation: state IDLE; counter 0; accumulators 0; md_result_o=0; md_valid_o=0; stall_o=0.
- Outputs during reset follow the combinational decode of current inputs with stall_o forced 0: aluoperacion_o, sel_md_o, illegal_o.

Optional Feature:
- ALU_MULDIV_EN defined: M-op decode and FSM present as described above.
- ALU_MULDIV_EN undefined: the FSM and datapath are not instantiated.
  - f7=0000001 on opcode 01100 is illegal (illegal_o=1, ADD).
  - stall_o, sel_md_o and md_valid_o are tied 0; md_result_o is tied 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op localparams.
  - Opcode constants (R, I, S, L, BR).
  - Funct7 constants.
  - M-op funct3 codes.
  - The FSM state enum.
- Sub-module muldiv_iter holds:
  - The operand registers, counter, iteration datapath, fast path and sign fix-up.
  - Its interface is start/f3/a/b in, busy/done/result out.
- The top level keeps decode, the state-to-stall mapping and the gating under ALU_MULDIV_EN.

Test Plan:
- R decode sweep: every legal {f7,f3} → exact code (e.g. 0100000/101 → 1011). f7=0100000/f3=111 → illegal_o=1, ADD.
- I decode: ADDI with f7=0100000 → 0010 and illegal_o=0. SRAI f7=0100000/101 → 1011. Branch f3=110 → 0110. S and L → 0010.
- MUL, XLEN=32: rs1=0xFFFFFFFF, rs2=0x00000003.
  - MUL → 0xFFFFFFFD.
  - MULHU → 0x00000002.
  - MULH → 0xFFFFFFFF.
  - Each has stall_o high for cycles 0–32 and md_valid_o pulsed in cycle 33.
- DIV rs1=-7, rs2=2 → quotient 0xFFFFFFFD. REM rs1=-7, rs2=2 → remainder 0xFFFFFFFF.
- DIVU by 0 → 0xFFFFFFFF in cycle 1. REM 0x80000000 / -1 → 0 in cycle 1.
- Assert rst_i in BUSY cycle 10 → next cycle IDLE with stall_o=0 and md_valid_o=0. A fresh M op is then accepted normally.

Source files
------------

// File: rtl/alu_ctrl_muldiv_pkg.sv
// rtl/alu_ctrl_muldiv_pkg.sv - shared constants for the ALU control decoder and multiply/divide engine
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    localparam logic [4:0] OPC_R  = 5'b01100;
    localparam logic [4:0] OPC_I  = 5'b00100;
    localparam logic [4:0] OPC_S  = 5'b01000;
    localparam logic [4:0] OPC_L  = 5'b00000;
    localparam logic [4:0] OPC_BR = 5'b11000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// rtl/alu_ctrl_muldiv_if.sv - decode-side bus between instruction decode and the ALU control block
interface alu_ctrl_muldiv_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [4:0]      opcode_i;
    logic [6:0]      f7_i;
    logic [2:0]      f3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [3:0]      aluoperacion_o;
    logic            sel_md_o;
    logic            stall_o;
    logic            md_valid_o;
    logic [XLEN-1:0] md_result_o;
    logic            illegal_o;

    modport master (
        output valid_i, opcode_i, f7_i, f3_i, rs1_i, rs2_i,
        input  aluoperacion_o, sel_md_o, stall_o, md_valid_o, md_result_o, illegal_o
    );

    modport slave (
        input  valid_i, opcode_i, f7_i, f3_i, rs1_i, rs2_i,
        output aluoperacion_o, sel_md_o, stall_o, md_valid_o, md_result_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_muldiv_iter.sv
// rtl/alu_ctrl_muldiv_iter.sv - iterative RV32M engine: shift-add multiply, restoring divide
// Works on operand magnitudes; signs are reapplied on the final iteration.
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [1:0] IDLE = MD_IDLE;
    localparam logic [1:0] BUSY = MD_BUSY;
    localparam logic [1:0] DONE = MD_DONE;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   ub;
    logic              neg_a_q, neg_b_q;
    logic [2:0]        f3_q;

    logic              signed_a, signed_b, sa, sb, fast;
    logic [XLEN-1:0]   ma, mb, fast_res;

    always_comb begin
        signed_a = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
        signed_b = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
        sa = signed_a & a[XLEN-1];
        sb = signed_b & b[XLEN-1];
        ma = sa ? (~a + 1'b1) : a;
        mb = sb ? (~b + 1'b1) : b;
        fast = 1'b0;
        fast_res = '0;
        // Division corner cases have architecturally fixed results and skip the iterations
        if (f3[2] && (b == '0)) begin
            fast = 1'b1;
            fast_res = f3[1] ? a : '1;
        end else if ((f3 == F3_DIV || f3 == F3_REM) && (a == INT_MIN) && (b == '1)) begin
            fast = 1'b1;
            fast_res = f3[1] ? '0 : a;
        end
    end

    logic [XLEN:0]     sum, rem_sh;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [XLEN-1:0]   dv;
    logic [XLEN-1:0]   fin;
    logic              neg;

    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, ub & {XLEN{acc[0]}}};
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        if (f3_q[2]) begin
            if (rem_sh >= {1'b0, ub}) begin
                acc_nxt = {rem_sh[XLEN-1:0] - ub, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
        // Remainder follows the dividend; quotient and product follow the sign product
        neg  = (f3_q[2] && f3_q[1]) ? neg_a_q : (neg_a_q ^ neg_b_q);
        prod = neg ? (~acc_nxt + 1'b1) : acc_nxt;
        dv   = f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (f3_q[2]) begin
            fin = neg ? (~dv + 1'b1) : dv;
        end else if (f3_q == F3_MUL) begin
            fin = prod[XLEN-1:0];
        end else begin
            fin = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            ub      <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            f3_q    <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        f3_q    <= f3;
                        neg_a_q <= sa;
                        neg_b_q <= sb;
                        ub      <= mb;
                        acc     <= {{XLEN{1'b0}}, ma};
                        cnt     <= CW'(XLEN);
                        if (fast) begin
                            result <= fast_res;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result <= fin;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - ALU control decoder with optional RV32M engine (enabled by ALU_MULDIV_EN)
// Decode is purely combinational; the engine only adds stall/writeback-select control.
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_ctrl_muldiv_if.slave   bus
);
    logic [3:0] alu_op;
    logic       illegal;
`ifdef ALU_MULDIV_EN
    logic       mop;
`endif

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b1;
`ifdef ALU_MULDIV_EN
        mop     = 1'b0;
`endif
        case (bus.opcode_i)
            OPC_R: begin
                if (bus.f7_i == F7_BASE) begin
                    illegal = 1'b0;
                    case (bus.f3_i)
                        3'b000:  alu_op = ALU_ADD;
                        3'b001:  alu_op = ALU_SLL;
                        3'b010:  alu_op = ALU_SLT;
                        3'b011:  alu_op = ALU_SLTU;
                        3'b100:  alu_op = ALU_XOR;
                        3'b101:  alu_op = ALU_SRL;
                        3'b110:  alu_op = ALU_OR;
                        default: alu_op = ALU_AND;
                    endcase
                end else if (bus.f7_i == F7_ALT) begin
                    if (bus.f3_i == 3'b000) begin
                        alu_op  = ALU_SUB;
                        illegal = 1'b0;
                    end else if (bus.f3_i == 3'b101) begin
                        alu_op  = ALU_SRA;
                        illegal = 1'b0;
                    end
                end
`ifdef ALU_MULDIV_EN
                else if (bus.f7_i == F7_MULDIV) begin
                    illegal = 1'b0;
                    mop     = 1'b1;
                end
`endif
            end
            OPC_I: begin
                illegal = 1'b0;
                case (bus.f3_i)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        if (bus.f7_i == F7_BASE) alu_op = ALU_SLL;
                        else                     illegal = 1'b1;
                    end
                    default: begin
                        if (bus.f7_i == F7_BASE)     alu_op = ALU_SRL;
                        else if (bus.f7_i == F7_ALT) alu_op = ALU_SRA;
                        else                         illegal = 1'b1;
                    end
                endcase
            end
            OPC_S, OPC_L: illegal = 1'b0;
            OPC_BR: begin
                illegal = 1'b0;
                case (bus.f3_i[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.aluoperacion_o = alu_op;
    assign bus.illegal_o      = illegal;

`ifdef ALU_MULDIV_EN
    logic            md_busy, md_done, start;
    logic [XLEN-1:0] md_res;

    // Accept only from IDLE, so the instruction still held in DONE is not relaunched
    assign start = bus.valid_i & mop & ~md_busy & ~md_done;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv_iter (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (start),
        .f3     (bus.f3_i),
        .a      (bus.rs1_i),
        .b      (bus.rs2_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
    );

    assign bus.stall_o     = ~rst_i & (start | md_busy);
    assign bus.sel_md_o    = mop;
    assign bus.md_valid_o  = ~rst_i & md_done;
    assign bus.md_result_o = md_res;
`else
    logic unused_inputs;
    assign unused_inputs   = ^{clk_i, rst_i, bus.valid_i, bus.rs1_i, bus.rs2_i};
    assign bus.stall_o     = 1'b0;
    assign bus.sel_md_o    = 1'b0;
    assign bus.md_valid_o  = 1'b0;
    assign bus.md_result_o = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb/tb_alu_ctrl_muldiv.sv - directed self-checking bench for alu_ctrl_muldiv (either ALU_MULDIV_EN build)
module tb_alu_ctrl_muldiv;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_muldiv_if #(.XLEN(32)) bus ();

    alu_ctrl_muldiv #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [4:0] opc, input logic [6:0] f7,
                       input logic [2:0] f3, input logic ill, input logic [3:0] op);
        bus.opcode_i = opc;
        bus.f7_i     = f7;
        bus.f3_i     = f3;
        #1;
        chk(tag, {27'd0, bus.illegal_o, bus.aluoperacion_o}, {27'd0, ill, op});
    endtask

    task automatic mop_run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic stall_hi;
        lat      = 0;
        stall_hi = 1'b1;
        bus.valid_i  = 1'b1;
        bus.opcode_i = OPC_R;
        bus.f7_i     = F7_MULDIV;
        bus.f3_i     = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        #1;
        chk({tag, "_stall_c0"}, 32'(bus.stall_o), 32'd1);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            bus.rs1_i = 32'hDEAD_BEEF;
            bus.rs2_i = 32'h1234_5678;
            #1;
            if (bus.md_valid_o) begin
                lat = c;
                break;
            end
            stall_hi = stall_hi & bus.stall_o;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, bus.md_result_o, exp);
        chk({tag, "_stall_done"}, 32'(bus.stall_o), 32'd0);
        if (exp_lat > 1) chk({tag, "_stall_busy"}, 32'(stall_hi), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        #1;
        chk({tag, "_valid_pulse"}, 32'(bus.md_valid_o), 32'd0);
    endtask

    logic [3:0] r_ops [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

    initial begin
        bus.valid_i  = 1'b0;
        bus.opcode_i = OPC_R;
        bus.f7_i     = F7_ALT;
        bus.f3_i     = 3'b000;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(bus.stall_o), 32'd0);
        chk("reset_md_valid", 32'(bus.md_valid_o), 32'd0);
        chk("reset_md_result", bus.md_result_o, 32'd0);
        chk("reset_decode_sub", 32'(bus.aluoperacion_o), 32'(ALU_SUB));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            dec($sformatf("r_base_f3_%0d", i), OPC_R, F7_BASE, 3'(i), 1'b0, r_ops[i]);
        end
        dec("r_sub", OPC_R, F7_ALT, 3'b000, 1'b0, ALU_SUB);
        dec("r_sra", OPC_R, F7_ALT, 3'b101, 1'b0, ALU_SRA);
        dec("r_alt_f3_7_illegal", OPC_R, F7_ALT, 3'b111, 1'b1, ALU_ADD);
        dec("i_addi_f7_alt", OPC_I, F7_ALT, 3'b000, 1'b0, ALU_ADD);
        dec("i_srai", OPC_I, F7_ALT, 3'b101, 1'b0, ALU_SRA);
        dec("i_srli", OPC_I, F7_BASE, 3'b101, 1'b0, ALU_SRL);
        dec("i_slli_bad_f7", OPC_I, F7_ALT, 3'b001, 1'b1, ALU_ADD);
        dec("i_andi", OPC_I, 7'b1111111, 3'b111, 1'b0, ALU_AND);
        dec("br_f3_110", OPC_BR, F7_BASE, 3'b110, 1'b0, ALU_SLTU);
        dec("br_f3_001", OPC_BR, F7_BASE, 3'b001, 1'b0, ALU_SUB);
        dec("br_f3_010_illegal", OPC_BR, F7_BASE, 3'b010, 1'b1, ALU_ADD);
        dec("store", OPC_S, F7_BASE, 3'b010, 1'b0, ALU_ADD);
        dec("load", OPC_L, F7_BASE, 3'b010, 1'b0, ALU_ADD);
        dec("bad_opcode", 5'b11111, F7_BASE, 3'b000, 1'b1, ALU_ADD);

`ifdef ALU_MULDIV_EN
        dec("m_decode", OPC_R, F7_MULDIV, F3_DIV, 1'b0, ALU_ADD);
        chk("m_sel_md", 32'(bus.sel_md_o), 32'd1);
        chk("m_no_valid_no_stall", 32'(bus.stall_o), 32'd0);

        mop_run("mul",    F3_MUL,    32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33);
        mop_run("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 33);
        mop_run("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 33);
        mop_run("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        mop_run("mulh_mm", F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        mop_run("div",    F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        mop_run("rem",    F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        mop_run("divu",   F3_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33);
        mop_run("remu",   F3_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33);
        mop_run("divu_by0", F3_DIVU, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        mop_run("remu_by0", F3_REMU, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
        mop_run("rem_ovf",  F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        mop_run("div_ovf",  F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        bus.valid_i  = 1'b1;
        bus.opcode_i = OPC_R;
        bus.f7_i     = F7_MULDIV;
        bus.f3_i     = F3_MUL;
        bus.rs1_i    = 32'd5;
        bus.rs2_i    = 32'd6;
        #1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_busy_c10_stall", 32'(bus.stall_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_mid_md_valid", 32'(bus.md_valid_o), 32'd0);
        chk("rst_mid_md_result", bus.md_result_o, 32'd0);
        mop_run("mul_after_rst", F3_MUL, 32'd5, 32'd6, 32'd30, 33);
`else
        bus.valid_i = 1'b1;
        bus.rs1_i   = 32'd3;
        bus.rs2_i   = 32'd5;
        dec("m_disabled_illegal", OPC_R, F7_MULDIV, F3_MUL, 1'b1, ALU_ADD);
        chk("m_disabled_sel_md", 32'(bus.sel_md_o), 32'd0);
        chk("m_disabled_stall_c0", 32'(bus.stall_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("m_disabled_stall_later", 32'(bus.stall_o), 32'd0);
        chk("m_disabled_md_valid", 32'(bus.md_valid_o), 32'd0);
        chk("m_disabled_md_result", bus.md_result_o, 32'd0);
        bus.valid_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
